fighter_player_ctrl: RTL and testbench
======================================

Name: fighter_player_ctrl

Overview:
- Per-player fighter controller; one instance per player, cross-coupled through opponent position and attack buses.
- Decodes a 10-bit controller word into moves, blocks and attacks, and resolves incoming hits with damage, saturation and death.
- Sequences per-state animation frames and packs the sprite word for the renderer.
- The game-flow FSM owns the tick strobes, enable and restart.

Parameters:
POS_W, 9, x/y position width
HEALTH_W, 6, health width
HEALTH_INIT, 31, health after reset/restart
DAMAGE, 10, health lost per landed hit
MOVE_STEP, 2, x pixels per game tick while walking
X_MIN, 0, left clamp
X_MAX, 300, right clamp
X_START, 20, x after reset/restart
JUMP_H, 24, posy while jumping
CLOSE_DIST, 56, hit range (strictly less than)
FRAME_W, 2, frame index width; 2^FRAME_W frames per animation

Ports:
clock  in  1  system clock
reset  in  1  async reset
restart  in  1  sync pulse: reload HEALTH_INIT/X_START, state IDLE
enable  in  1  game running; low freezes all state
game_tick  in  1  one-cycle strobe, input/hit evaluation rate
frame_tick  in  1  one-cycle strobe, animation rate
buttons  in  10  [0]left [1]right [2]duck [3]jump [4]block [5]atk_low [6]atk_mid [7]atk_high [9:8]ignored
opp_posx  in  POS_W  opponent x
opp_attack  in  2  opponent attack level (0 none, 1 low, 2 mid, 3 high)
posx  out  POS_W  own x
attack  out  2  own attack level, non-zero only in ATTACK state
health  out  HEALTH_W  own health
dead  out  1  high in DEAD
facing_left  out  1  opponent is to the left
sprite  out  2*POS_W+HEALTH_W+8  {posx, posy, health, facing_left, anim[3:0], frame[FRAME_W-1:0], hit}; FRAME_W=2 gives 32 bits

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clock.
- Reset state:
  - IDLE; health=HEALTH_INIT; posx=X_START; posy=0; frame=0; attack=0; dead=0; facing_left=0; sprite=0; prev_opp_atk=0.
  - restart has the same effect synchronously.
- Enable: when enable=0, ticks are ignored and all registers hold. restart overrides enable.
- States and anim codes: IDLE 0, WALK 1, DUCK 2, JUMP 3, BLOCK 4, ATTACK 5/6/7 (low/mid/high), HIT 8, DEAD 9.
- Input decode, on game_tick from IDLE/WALK/DUCK/BLOCK only:
  - Priority: atk_high > atk_mid > atk_low > block > jump > duck > left/right > none.
  - Left and right together count as none.
  - Outcomes: ATTACK (latch level), BLOCK, JUMP, DUCK, WALK, or IDLE.
  - ATTACK, JUMP and HIT are one-shot and ignore buttons until finished.
- Movement: in WALK, each game_tick adds or subtracts MOVE_STEP, clamped to [X_MIN, X_MAX] with no wrap-around (the subtraction must not underflow).
- posy: JUMP_H in JUMP, otherwise 0.
- Facing:
  - facing_left=1 when opp_posx<posx, 0 when opp_posx>posx.
  - Equal positions hold the previous value.
  - Updated every enabled cycle.
- Hit resolution, on game_tick:
  - Sample opp_attack. A new attack is non-zero with prev_opp_atk==0, or a level different from the previous sample.
  - The hit lands when the attack is new, |posx−opp_posx|<CLOSE_DIST, and the player is not protected.
  - Protection: BLOCK stops all levels; JUMP evades low; DUCK evades high.
  - A landed hit sets health = max(health−DAMAGE, 0), enters HIT, and restarts the frame at 0.
  - A hit interrupts ATTACK and re-triggers HIT.
  - Distance is computed unsigned as an absolute difference.
- Death: health==0 after a hit enters DEAD and sets dead=1. DEAD is absorbing until restart or reset; ticks are ignored.
- Animation:
  - Each state change sets frame=0 in the same register update.
  - frame_tick increments frame.
  - IDLE/WALK/DUCK/BLOCK loop, wrapping from max to 0.
  - ATTACK/JUMP/HIT: a frame_tick at max frame returns to IDLE with frame 0, attack=0 and posy=0.
  - DEAD stops at max frame.
- Simultaneous game_tick and frame_tick:
  - A landed hit wins over animation end.
  - Animation end wins over button decode; buttons are next evaluated on the following game_tick.
- hit bit is high while in HIT.
- Latency:
  - State, posx, health, attack and dead update on the clock edge of the tick cycle.
  - sprite is registered one cycle later.

Test Plan:
- Reset, enable=1, buttons[1] held for 5 game_ticks -> posx 20→30, anim=1, facing_left=0 with opp_posx=200; sprite=0 during reset.
- posx=2, buttons[0] held for 3 ticks -> posx 0, stays 0 with no wrap to 510.
- opp_posx=posx+40, opp_attack 0→2 on a tick while IDLE -> health 31→21, anim=8, hit=1; opp_attack held at 2 on later ticks -> no further damage; after 4 frame_ticks -> IDLE.
- Same attack while BLOCK -> health unchanged. Low attack while JUMP -> unchanged. High while DUCK -> unchanged. Any attack with distance 56 -> unchanged.
- Four landed hits from 31 -> 21, 11, 1, 0; dead=1, anim=9; buttons ignored; restart pulse -> health 31, posx 20, IDLE, dead=0.
- buttons[7] while IDLE -> attack=3, anim=7; game_tick and frame_tick coincide at frame 3 -> IDLE, attack=0 on the same edge.

Source files
------------

// File: rtl/fighter_player_ctrl.sv
// ============================================================================
// fighter_player_ctrl: per-player fighter controller (input decode, movement,
// hit resolution, animation sequencing, sprite packing)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fighter_player_ctrl #(
    parameter int POS_W       = 9,
    parameter int HEALTH_W    = 6,
    parameter int HEALTH_INIT = 31,
    parameter int DAMAGE      = 10,
    parameter int MOVE_STEP   = 2,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 300,
    parameter int X_START     = 20,
    parameter int JUMP_H      = 24,
    parameter int CLOSE_DIST  = 56,
    parameter int FRAME_W     = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              restart,
    input  logic                              enable,
    input  logic                              game_tick,
    input  logic                              frame_tick,
    input  logic [9:0]                        buttons,
    input  logic [POS_W-1:0]                  opp_posx,
    input  logic [1:0]                        opp_attack,
    output logic [POS_W-1:0]                  posx,
    output logic [1:0]                        attack,
    output logic [HEALTH_W-1:0]               health,
    output logic                              dead,
    output logic                              facing_left,
    output logic [2*POS_W+HEALTH_W+FRAME_W+5:0] sprite
);

    localparam int SPRITE_W = 2*POS_W + HEALTH_W + FRAME_W + 6;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WALK   = 4'd1,
        S_DUCK   = 4'd2,
        S_JUMP   = 4'd3,
        S_BLOCK  = 4'd4,
        S_ATTACK = 4'd5,
        S_HIT    = 4'd8,
        S_DEAD   = 4'd9
    } state_t;

    state_t                r_state;
    logic [POS_W-1:0]      r_posx;
    logic [HEALTH_W-1:0]   r_health;
    logic [FRAME_W-1:0]    r_frame;
    logic [1:0]            r_attack;
    logic [1:0]            r_prev_atk;
    logic                  r_dead;
    logic                  r_facing;
    logic [SPRITE_W-1:0]   r_sprite;

    logic [POS_W-1:0]      w_dist;
    logic                  w_in_range;
    logic                  w_new_atk;
    logic                  w_protected;
    logic                  w_hit_lands;
    logic [HEALTH_W-1:0]   w_health_dmg;
    logic                  w_oneshot;
    logic                  w_anim_end;
    logic [POS_W:0]        w_right_sum;
    logic [POS_W-1:0]      w_posx_right;
    logic [POS_W-1:0]      w_posx_left;
    logic [POS_W-1:0]      w_posy;
    logic [3:0]            w_anim;
    logic                  w_hit_bit;
    state_t                w_dec_state;
    logic [1:0]            w_dec_lvl;
    logic                  w_unused;

    assign w_unused = ^buttons[9:8];

    assign w_dist      = (r_posx >= opp_posx) ? (r_posx - opp_posx) : (opp_posx - r_posx);
    assign w_in_range  = (w_dist < POS_W'(CLOSE_DIST));
    // A level change counts as a fresh attack, a held level does not.
    assign w_new_atk   = (opp_attack != 2'd0) && (opp_attack != r_prev_atk);
    assign w_protected = (r_state == S_BLOCK)
                       || ((r_state == S_JUMP) && (opp_attack == 2'd1))
                       || ((r_state == S_DUCK) && (opp_attack == 2'd3));
    assign w_hit_lands = game_tick && w_new_atk && w_in_range && !w_protected;
    assign w_health_dmg = (r_health > HEALTH_W'(DAMAGE)) ? (r_health - HEALTH_W'(DAMAGE)) : '0;

    assign w_oneshot  = (r_state == S_ATTACK) || (r_state == S_JUMP) || (r_state == S_HIT);
    assign w_anim_end = frame_tick && (&r_frame) && w_oneshot;

    assign w_right_sum  = {1'b0, r_posx} + (POS_W+1)'(MOVE_STEP);
    assign w_posx_right = (w_right_sum > (POS_W+1)'(X_MAX)) ? POS_W'(X_MAX) : w_right_sum[POS_W-1:0];
    assign w_posx_left  = ({1'b0, r_posx} < (POS_W+1)'(X_MIN + MOVE_STEP)) ? POS_W'(X_MIN)
                                                                          : (r_posx - POS_W'(MOVE_STEP));

    assign w_posy    = (r_state == S_JUMP) ? POS_W'(JUMP_H) : '0;
    assign w_anim    = (r_state == S_ATTACK) ? {2'b01, r_attack} : r_state;
    assign w_hit_bit = (r_state == S_HIT);

    always_comb begin
        w_dec_state = S_IDLE;
        w_dec_lvl   = 2'd0;
        if (buttons[7]) begin
            w_dec_state = S_ATTACK;
            w_dec_lvl   = 2'd3;
        end else if (buttons[6]) begin
            w_dec_state = S_ATTACK;
            w_dec_lvl   = 2'd2;
        end else if (buttons[5]) begin
            w_dec_state = S_ATTACK;
            w_dec_lvl   = 2'd1;
        end else if (buttons[4]) begin
            w_dec_state = S_BLOCK;
        end else if (buttons[3]) begin
            w_dec_state = S_JUMP;
        end else if (buttons[2]) begin
            w_dec_state = S_DUCK;
        end else if (buttons[0] ^ buttons[1]) begin
            w_dec_state = S_WALK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_posx     <= POS_W'(X_START);
            r_health   <= HEALTH_W'(HEALTH_INIT);
            r_frame    <= '0;
            r_attack   <= 2'd0;
            r_prev_atk <= 2'd0;
            r_dead     <= 1'b0;
            r_facing   <= 1'b0;
            r_sprite   <= '0;
        end else if (restart) begin
            r_state    <= S_IDLE;
            r_posx     <= POS_W'(X_START);
            r_health   <= HEALTH_W'(HEALTH_INIT);
            r_frame    <= '0;
            r_attack   <= 2'd0;
            r_prev_atk <= 2'd0;
            r_dead     <= 1'b0;
            r_facing   <= 1'b0;
            r_sprite   <= '0;
        end else if (enable) begin
            if (opp_posx < r_posx) begin
                r_facing <= 1'b1;
            end else if (opp_posx > r_posx) begin
                r_facing <= 1'b0;
            end
            r_sprite <= {r_posx, w_posy, r_health, r_facing, w_anim, r_frame, w_hit_bit};

            if (r_state == S_DEAD) begin
                if (frame_tick && !(&r_frame)) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end else begin
                if (game_tick) begin
                    r_prev_atk <= opp_attack;
                end
                // Priority: landed hit > one-shot animation end > button decode.
                if (w_hit_lands) begin
                    r_health <= w_health_dmg;
                    r_frame  <= '0;
                    r_attack <= 2'd0;
                    if (w_health_dmg == '0) begin
                        r_state <= S_DEAD;
                        r_dead  <= 1'b1;
                    end else begin
                        r_state <= S_HIT;
                    end
                end else if (w_anim_end) begin
                    r_state  <= S_IDLE;
                    r_frame  <= '0;
                    r_attack <= 2'd0;
                end else if (game_tick && !w_oneshot) begin
                    r_state  <= w_dec_state;
                    r_attack <= w_dec_lvl;
                    if (w_dec_state == S_WALK) begin
                        r_posx <= buttons[0] ? w_posx_left : w_posx_right;
                    end
                    if (w_dec_state != r_state) begin
                        r_frame <= '0;
                    end else if (frame_tick) begin
                        r_frame <= r_frame + FRAME_W'(1);
                    end
                end else if (frame_tick) begin
                    r_frame <= r_frame + FRAME_W'(1);
                end
            end
        end
    end

    assign posx        = r_posx;
    assign attack      = r_attack;
    assign health      = r_health;
    assign dead        = r_dead;
    assign facing_left = r_facing;
    assign sprite      = r_sprite;

endmodule

`default_nettype wire

// File: tb/tb_fighter_player_ctrl.sv
// ============================================================================
// tb_fighter_player_ctrl: directed self-checking bench for fighter_player_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fighter_player_ctrl;

    logic        clock;
    logic        reset;
    logic        restart;
    logic        enable;
    logic        game_tick;
    logic        frame_tick;
    logic [9:0]  buttons;
    logic [8:0]  opp_posx;
    logic [1:0]  opp_attack;
    logic [8:0]  posx;
    logic [1:0]  attack;
    logic [5:0]  health;
    logic        dead;
    logic        facing_left;
    logic [31:0] sprite;

    int total = 0;
    int bad   = 0;

    fighter_player_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .restart     (restart),
        .enable      (enable),
        .game_tick   (game_tick),
        .frame_tick  (frame_tick),
        .buttons     (buttons),
        .opp_posx    (opp_posx),
        .opp_attack  (opp_attack),
        .posx        (posx),
        .attack      (attack),
        .health      (health),
        .dead        (dead),
        .facing_left (facing_left),
        .sprite      (sprite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] spr(input logic [8:0] px, input logic [8:0] py,
                                        input logic [5:0] hp, input logic fl,
                                        input logic [3:0] an, input logic [1:0] fr,
                                        input logic ht);
        return {px, py, hp, fl, an, fr, ht};
    endfunction

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input logic gt, input logic ft);
        game_tick  = gt;
        frame_tick = ft;
        @(posedge clock);
        #1;
        game_tick  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clock);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; enable = 1'b0;
        game_tick = 1'b0; frame_tick = 1'b0;
        buttons = '0; opp_posx = 9'd200; opp_attack = 2'd0;
        clk1(); clk1();
        chk("rst_sprite", sprite, 32'd0);
        chk("rst_health", health, 32'd31);
        chk("rst_posx",   posx,   32'd20);
        chk("rst_dead",   dead,   32'd0);
        chk("rst_attack", attack, 32'd0);
        chk("rst_facing", facing_left, 32'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Walk right five ticks
        buttons = 10'h002;
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("walk_r_posx", posx, 32'd30);
        clk1();
        chk("walk_r_sprite", sprite, spr(9'd30, 9'd0, 6'd31, 1'b0, 4'd1, 2'd0, 1'b0));

        // Walk left down to the clamp
        buttons = 10'h001;
        for (int i = 0; i < 14; i++) tick(1'b1, 1'b0);
        chk("walk_l_posx2", posx, 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0);
            chk("walk_l_clamp", posx, 32'd0);
        end

        // Landed mid attack, held level does not re-hit, HIT runs 4 frames
        buttons = '0;
        tick(1'b1, 1'b0);
        opp_posx = 9'd40;
        opp_attack = 2'd2;
        tick(1'b1, 1'b0);
        chk("hit1_health", health, 32'd21);
        clk1();
        chk("hit1_sprite", sprite, spr(9'd0, 9'd0, 6'd21, 1'b0, 4'd8, 2'd0, 1'b1));
        tick(1'b1, 1'b0);
        chk("held_atk_health", health, 32'd21);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        clk1();
        chk("hit_end_sprite", sprite, spr(9'd0, 9'd0, 6'd21, 1'b0, 4'd0, 2'd0, 1'b0));
        opp_attack = 2'd0;
        tick(1'b1, 1'b0);

        // Block stops a mid attack
        buttons = 10'h010;
        tick(1'b1, 1'b0);
        opp_attack = 2'd2;
        tick(1'b1, 1'b0);
        chk("block_health", health, 32'd21);
        opp_attack = 2'd0;
        tick(1'b1, 1'b0);

        // Jump evades a low attack
        buttons = 10'h008;
        tick(1'b1, 1'b0);
        clk1();
        chk("jump_sprite", sprite, spr(9'd0, 9'd24, 6'd21, 1'b0, 4'd3, 2'd0, 1'b0));
        opp_attack = 2'd1;
        tick(1'b1, 1'b0);
        chk("jump_low_health", health, 32'd21);
        opp_attack = 2'd0;
        buttons = '0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);

        // Duck evades a high attack
        buttons = 10'h004;
        tick(1'b1, 1'b0);
        opp_attack = 2'd3;
        tick(1'b1, 1'b0);
        chk("duck_high_health", health, 32'd21);
        opp_attack = 2'd0;
        tick(1'b1, 1'b0);

        // Distance exactly 56 is out of range
        buttons = '0;
        tick(1'b1, 1'b0);
        opp_posx = 9'd56;
        opp_attack = 2'd2;
        tick(1'b1, 1'b0);
        chk("dist56_health", health, 32'd21);
        opp_attack = 2'd0;
        tick(1'b1, 1'b0);

        // Four hits from full health down to death
        pulse_restart();
        chk("restart1_health", health, 32'd31);
        chk("restart1_sprite", sprite, 32'd0);
        opp_posx = 9'd60;
        for (int i = 0; i < 4; i++) begin
            opp_attack = 2'd2;
            tick(1'b1, 1'b0);
            chk("chain_health", health, (i < 3) ? 32'(21 - 10 * i) : 32'd0);
            opp_attack = 2'd0;
            tick(1'b1, 1'b0);
        end
        chk("dead_flag", dead, 32'd1);
        clk1();
        chk("dead_sprite", sprite, spr(9'd20, 9'd0, 6'd0, 1'b0, 4'd9, 2'd0, 1'b0));
        buttons = 10'h002;
        tick(1'b1, 1'b0);
        chk("dead_ignores_btn", posx, 32'd20);
        buttons = '0;
        pulse_restart();
        chk("restart2_health", health, 32'd31);
        chk("restart2_dead", dead, 32'd0);
        chk("restart2_posx", posx, 32'd20);
        clk1();
        chk("restart2_sprite", sprite, spr(9'd20, 9'd0, 6'd31, 1'b0, 4'd0, 2'd0, 1'b0));

        // High attack, animation end beats decode on a coincident tick
        buttons = 10'h080;
        tick(1'b1, 1'b0);
        chk("atk_high_level", attack, 32'd3);
        buttons = '0;
        clk1();
        chk("atk_high_sprite", sprite, spr(9'd20, 9'd0, 6'd31, 1'b0, 4'd7, 2'd0, 1'b0));
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        buttons = 10'h080;
        tick(1'b1, 1'b1);
        chk("atk_end_attack", attack, 32'd0);
        buttons = '0;
        clk1();
        chk("atk_end_sprite", sprite, spr(9'd20, 9'd0, 6'd31, 1'b0, 4'd0, 2'd0, 1'b0));

        // Disabled: ticks ignored
        enable = 1'b0;
        buttons = 10'h002;
        tick(1'b1, 1'b0);
        chk("disabled_posx", posx, 32'd20);
        enable = 1'b1;
        buttons = '0;

        // Opponent moves to the left
        opp_posx = 9'd5;
        clk1();
        chk("facing_left", facing_left, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
